// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the accumulator CPU control unit: state codes, opcodes,
// control-word bit indices and opcode classification. Optional CTRL_STEP_EN adds single-step.
package cpu_ctrl_pkg;

    localparam int unsigned CW_DEFAULT  = 32;
    localparam int unsigned OPW_DEFAULT = 8;
    localparam int unsigned SW          = 4;

    localparam logic [SW-1:0] S_IDLE   = 4'd0;
    localparam logic [SW-1:0] S_F0     = 4'd1;
    localparam logic [SW-1:0] S_F1     = 4'd2;
    localparam logic [SW-1:0] S_F2     = 4'd3;
    localparam logic [SW-1:0] S_DEC    = 4'd4;
    localparam logic [SW-1:0] S_RD     = 4'd5;
    localparam logic [SW-1:0] S_BR     = 4'd6;
    localparam logic [SW-1:0] S_CLR    = 4'd7;
    localparam logic [SW-1:0] S_ALU    = 4'd8;
    localparam logic [SW-1:0] S_UNARY  = 4'd9;
    localparam logic [SW-1:0] S_ST_MBR = 4'd10;
    localparam logic [SW-1:0] S_ST_WR  = 4'd11;
    localparam logic [SW-1:0] S_JMP    = 4'd12;
    localparam logic [SW-1:0] S_HALT   = 4'd13;

    localparam logic [7:0] OP_STORE  = 8'h01;
    localparam logic [7:0] OP_LOAD   = 8'h02;
    localparam logic [7:0] OP_ADD    = 8'h03;
    localparam logic [7:0] OP_SUB    = 8'h04;
    localparam logic [7:0] OP_JMPGEZ = 8'h05;
    localparam logic [7:0] OP_JMP    = 8'h06;
    localparam logic [7:0] OP_HALT   = 8'h07;
    localparam logic [7:0] OP_MPY    = 8'h08;
    localparam logic [7:0] OP_AND    = 8'h0A;
    localparam logic [7:0] OP_OR     = 8'h0B;
    localparam logic [7:0] OP_NOT    = 8'h0C;
    localparam logic [7:0] OP_SHR    = 8'h0D;
    localparam logic [7:0] OP_SHL    = 8'h0E;

    localparam int unsigned B_MAR_PC  = 0;
    localparam int unsigned B_PC_INC  = 1;
    localparam int unsigned B_MBR_MEM = 2;
    localparam int unsigned B_IR_MBR  = 3;
    localparam int unsigned B_MAR_MBR = 4;
    localparam int unsigned B_MEM_MBR = 5;
    localparam int unsigned B_MBR_ACC = 6;
    localparam int unsigned B_BR_MBR  = 7;
    localparam int unsigned B_ACC_CLR = 8;
    localparam int unsigned B_ADD     = 9;
    localparam int unsigned B_SUB     = 10;
    localparam int unsigned B_AND     = 11;
    localparam int unsigned B_OR      = 12;
    localparam int unsigned B_NOT     = 13;
    localparam int unsigned B_SHL     = 14;
    localparam int unsigned B_SHR     = 15;
    localparam int unsigned B_MPY     = 16;
    localparam int unsigned B_PC_JMP  = 17;
    localparam int unsigned B_HALT    = 18;

    typedef enum logic [2:0] {
        CLS_ILLEGAL,
        CLS_MEM_ALU,
        CLS_UNARY,
        CLS_STORE,
        CLS_JUMP,
        CLS_HALT
    } op_class_e;

    function automatic op_class_e op_class(input logic [7:0] op);
        op_class_e cls;
        case (op)
            OP_LOAD, OP_ADD, OP_SUB,
            OP_AND, OP_OR, OP_MPY:  cls = CLS_MEM_ALU;
            OP_NOT, OP_SHL, OP_SHR: cls = CLS_UNARY;
            OP_STORE:               cls = CLS_STORE;
            OP_JMP, OP_JMPGEZ:      cls = CLS_JUMP;
            OP_HALT:                cls = CLS_HALT;
            default:                cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/cpu_ctrl_sequencer_if.sv
// Control-unit handshake bundle between the sequencer (master) and the datapath (slave).
// CTRL_STEP_EN adds the single-step request line.
interface cpu_ctrl_sequencer_if #(
    parameter int unsigned CW  = 32,
    parameter int unsigned OPW = 8
);
    logic           start;
    logic [OPW-1:0] opcode;
    logic           acc_neg;
    logic           mem_ready;
`ifdef CTRL_STEP_EN
    logic           step;
`endif
    logic [CW-1:0]  control_signal;
    logic           halted;
    logic           illegal_op;

`ifdef CTRL_STEP_EN
    modport master (
        input  start, opcode, acc_neg, mem_ready, step,
        output control_signal, halted, illegal_op
    );
    modport slave (
        output start, opcode, acc_neg, mem_ready, step,
        input  control_signal, halted, illegal_op
    );
`else
    modport master (
        input  start, opcode, acc_neg, mem_ready,
        output control_signal, halted, illegal_op
    );
    modport slave (
        output start, opcode, acc_neg, mem_ready,
        input  control_signal, halted, illegal_op
    );
`endif

endinterface

// File: rtl/cpu_ctrl_decode.sv
// Combinational control-word decoder: current state plus live inputs -> datapath control word.
// Under CTRL_STEP_EN the caller gates the F0 word through f0_go.
module cpu_ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned CW = CW_DEFAULT
) (
    input  logic [SW-1:0] state,
    input  logic [7:0]    opcode,
    input  logic          acc_neg,
    input  logic          mem_ready,
    input  logic          f0_go,
    output logic [CW-1:0] ctrl,
    output logic          illegal_op
);

    always_comb begin
        ctrl       = '0;
        illegal_op = 1'b0;
        case (state)
            S_F0:     ctrl[B_MAR_PC] = f0_go;
            // PC advances only in the F1 cycle that completes the read
            S_F1: begin
                ctrl[B_MBR_MEM] = 1'b1;
                ctrl[B_PC_INC]  = mem_ready;
            end
            S_F2: begin
                ctrl[B_IR_MBR]  = 1'b1;
                ctrl[B_MAR_MBR] = 1'b1;
            end
            S_DEC:    illegal_op = (op_class(opcode) == CLS_ILLEGAL);
            S_RD:     ctrl[B_MBR_MEM] = 1'b1;
            S_BR:     ctrl[B_BR_MBR]  = 1'b1;
            S_CLR:    ctrl[B_ACC_CLR] = 1'b1;
            S_ALU: begin
                case (opcode)
                    OP_LOAD, OP_ADD: ctrl[B_ADD] = 1'b1;
                    OP_SUB:          ctrl[B_SUB] = 1'b1;
                    OP_AND:          ctrl[B_AND] = 1'b1;
                    OP_OR:           ctrl[B_OR]  = 1'b1;
                    OP_MPY:          ctrl[B_MPY] = 1'b1;
                    default:         ctrl        = '0;
                endcase
            end
            S_UNARY: begin
                case (opcode)
                    OP_NOT:  ctrl[B_NOT] = 1'b1;
                    OP_SHL:  ctrl[B_SHL] = 1'b1;
                    OP_SHR:  ctrl[B_SHR] = 1'b1;
                    default: ctrl        = '0;
                endcase
            end
            S_ST_MBR: ctrl[B_MBR_ACC] = 1'b1;
            S_ST_WR:  ctrl[B_MEM_MBR] = 1'b1;
            S_JMP:    ctrl[B_PC_JMP]  = (opcode == OP_JMP) ||
                                        ((opcode == OP_JMPGEZ) && !acc_neg);
            S_HALT:   ctrl[B_HALT]    = 1'b1;
            default:  ctrl            = '0;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_sequencer.sv
// Hardwired fetch/decode/execute sequencer of the accumulator CPU: state register,
// next-state logic and decoder instance. Define CTRL_STEP_EN for single-instruction stepping.
module cpu_ctrl_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned CW  = CW_DEFAULT,
    parameter int unsigned OPW = OPW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    cpu_ctrl_sequencer_if.master bus
);

    logic [SW-1:0]  state_q;
    logic [SW-1:0]  state_d;
    logic [OPW-1:0] opcode_w;
    logic [7:0]     op_b;
    logic           f0_go;
    logic [CW-1:0]  ctrl_word;
    logic           illegal_w;

    assign opcode_w = bus.opcode;
    assign op_b     = opcode_w[7:0];

`ifdef CTRL_STEP_EN
    assign f0_go = bus.step;
`else
    assign f0_go = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_F0;
            S_F0:     if (f0_go) state_d = S_F1;
            S_F1:     if (bus.mem_ready) state_d = S_F2;
            S_F2:     state_d = S_DEC;
            S_DEC: begin
                case (op_class(op_b))
                    CLS_MEM_ALU: state_d = S_RD;
                    CLS_UNARY:   state_d = S_UNARY;
                    CLS_STORE:   state_d = S_ST_MBR;
                    CLS_JUMP:    state_d = S_JMP;
                    CLS_HALT:    state_d = S_HALT;
                    default:     state_d = S_F0;
                endcase
            end
            S_RD:     if (bus.mem_ready) state_d = S_BR;
            // LOAD reuses the ALU add cycle after clearing ACC
            S_BR:     state_d = (op_b == OP_LOAD) ? S_CLR : S_ALU;
            S_CLR:    state_d = S_ALU;
            S_ALU,
            S_UNARY,
            S_JMP:    state_d = S_F0;
            S_ST_MBR: state_d = S_ST_WR;
            S_ST_WR:  if (bus.mem_ready) state_d = S_F0;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    cpu_ctrl_decode #(
        .CW (CW)
    ) u_decode (
        .state      (state_q),
        .opcode     (op_b),
        .acc_neg    (bus.acc_neg),
        .mem_ready  (bus.mem_ready),
        .f0_go      (f0_go),
        .ctrl       (ctrl_word),
        .illegal_op (illegal_w)
    );

    assign bus.control_signal = ctrl_word;
    assign bus.illegal_op     = illegal_w;
    assign bus.halted         = (state_q == S_HALT);

endmodule

// File: tb/tb_cpu_ctrl_sequencer.sv
// Self-checking bench for cpu_ctrl_sequencer: directed per-cycle tables plus randomized
// instructions against an instruction-level reference model.
module tb_cpu_ctrl_sequencer;

    logic clk;
    logic rst;

    cpu_ctrl_sequencer_if #(.CW(32), .OPW(8)) bus ();

    cpu_ctrl_sequencer #(.CW(32), .OPW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mr;
        logic        an;
        logic        st;
        logic [7:0]  op;
        logic [31:0] word;
        logic        halt;
        logic        ill;
    } row_t;

    row_t rows[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [31:0] bitw(input int unsigned n);
        return 32'(1) << n;
    endfunction

    function automatic void push(input logic mr, input logic an, input logic st,
                                 input logic [7:0] op, input logic [31:0] w,
                                 input logic h, input logic il);
        row_t r;
        r.mr = mr; r.an = an; r.st = st; r.op = op;
        r.word = w; r.halt = h; r.ill = il;
        rows.push_back(r);
    endfunction

    // Fixed F0/F1/F2/DECODE prefix for the directed tables
    function automatic void hand_fetch(input logic [7:0] op, input int unsigned f1w,
                                       input logic il);
        push(1'b1, 1'b0, 1'b0, op, 32'h1, 1'b0, 1'b0);
        for (int unsigned i = 0; i < f1w; i++) push(1'b0, 1'b0, 1'b0, op, 32'h4, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b0, op, 32'h6, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b0, op, 32'h18, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b0, op, 32'h0, 1'b0, il);
    endfunction

    // Reference model: one whole instruction expanded into expected cycles
    function automatic void model_instr(input logic [7:0] op, input int unsigned f1w,
                                        input int unsigned rdw, input int unsigned stw);
        logic an;
        logic legal;
        int   alu;
        legal = 1'b1;
        alu   = -1;
        case (op)
            8'h02, 8'h03: alu = 9;
            8'h04:        alu = 10;
            8'h0A:        alu = 11;
            8'h0B:        alu = 12;
            8'h08:        alu = 16;
            8'h01, 8'h05, 8'h06, 8'h0C, 8'h0D, 8'h0E: legal = 1'b1;
            default:      legal = 1'b0;
        endcase
        push(rb(), rb(), rb(), op, 32'h1, 1'b0, 1'b0);
        for (int unsigned i = 0; i < f1w; i++) push(1'b0, rb(), rb(), op, 32'h4, 1'b0, 1'b0);
        push(1'b1, rb(), rb(), op, 32'h6, 1'b0, 1'b0);
        push(rb(), rb(), rb(), op, 32'h18, 1'b0, 1'b0);
        push(rb(), rb(), rb(), op, 32'h0, 1'b0, !legal);
        if (alu >= 0) begin
            for (int unsigned i = 0; i < rdw; i++) push(1'b0, rb(), rb(), op, 32'h4, 1'b0, 1'b0);
            push(1'b1, rb(), rb(), op, 32'h4, 1'b0, 1'b0);
            push(rb(), rb(), rb(), op, 32'h80, 1'b0, 1'b0);
            if (op == 8'h02) push(rb(), rb(), rb(), op, 32'h100, 1'b0, 1'b0);
            push(rb(), rb(), rb(), op, bitw(alu), 1'b0, 1'b0);
        end else begin
            case (op)
                8'h0C: push(rb(), rb(), rb(), op, bitw(13), 1'b0, 1'b0);
                8'h0E: push(rb(), rb(), rb(), op, bitw(14), 1'b0, 1'b0);
                8'h0D: push(rb(), rb(), rb(), op, bitw(15), 1'b0, 1'b0);
                8'h06: push(rb(), rb(), rb(), op, bitw(17), 1'b0, 1'b0);
                8'h05: begin
                    an = rb();
                    push(rb(), an, rb(), op, an ? 32'h0 : bitw(17), 1'b0, 1'b0);
                end
                8'h01: begin
                    push(rb(), rb(), rb(), op, 32'h40, 1'b0, 1'b0);
                    for (int unsigned i = 0; i < stw; i++) push(1'b0, rb(), rb(), op, 32'h20, 1'b0, 1'b0);
                    push(1'b1, rb(), rb(), op, 32'h20, 1'b0, 1'b0);
                end
                default: ;
            endcase
        end
    endfunction

    task automatic check_now(input string tag, input logic [31:0] w,
                             input logic h, input logic il);
        n_cmp++;
        if ({bus.control_signal, bus.halted, bus.illegal_op} !== {w, h, il}) begin
            n_bad++;
            $display("FAIL %s: got ctrl=%h halted=%b illegal=%b, expected ctrl=%h halted=%b illegal=%b",
                     tag, bus.control_signal, bus.halted, bus.illegal_op, w, h, il);
        end
    endtask

    task automatic apply_rows(input string tag);
        row_t r;
        while (rows.size() > 0) begin
            r = rows.pop_front();
            @(posedge clk);
            #1;
            bus.mem_ready = r.mr;
            bus.acc_neg   = r.an;
            bus.start     = r.st;
            bus.opcode    = r.op;
            @(negedge clk);
            check_now(tag, r.word, r.halt, r.ill);
        end
    endtask

    task automatic release_rst(input logic st);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.start     = st;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check_now("idle_after_rst", 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] mem_ops[4];
        int unsigned mem_bit[4];
        logic [7:0] un_ops[3];
        int unsigned un_bit[3];
        logic [7:0] rop;

        mem_ops = '{8'h04, 8'h0A, 8'h0B, 8'h08};
        mem_bit = '{10, 11, 12, 16};
        un_ops  = '{8'h0C, 8'h0E, 8'h0D};
        un_bit  = '{13, 14, 15};

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.opcode    = 8'h00;
        bus.acc_neg   = 1'b0;
        bus.mem_ready = 1'b0;
`ifdef CTRL_STEP_EN
        bus.step      = 1'b1;
`endif
        repeat (2) begin
            @(negedge clk);
            check_now("reset_state", 32'h0, 1'b0, 1'b0);
        end
        release_rst(1'b0);
        push(1'b1, 1'b0, 1'b0, 8'h03, 32'h0, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b0, 8'h03, 32'h0, 1'b0, 1'b0);
        apply_rows("idle_hold");

        // Directed vectors; start is high only in the final IDLE cycle
        push(1'b1, 1'b0, 1'b1, 8'h03, 32'h0, 1'b0, 1'b0);
        hand_fetch(8'h03, 0, 1'b0);
        push(1'b1, 1'b0, 1'b0, 8'h03, 32'h4, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b0, 8'h03, 32'h80, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b0, 8'h03, 32'h200, 1'b0, 1'b0);
        apply_rows("add_vec");

        hand_fetch(8'h02, 2, 1'b0);
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b0, 8'h02, 32'h4, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b0, 8'h02, 32'h4, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0, 8'h02, 32'h80, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0, 8'h02, 32'h100, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0, 8'h02, 32'h200, 1'b0, 1'b0);
        apply_rows("load_waits");

        hand_fetch(8'h05, 0, 1'b0);
        push(1'b1, 1'b0, 1'b0, 8'h05, 32'h20000, 1'b0, 1'b0);
        hand_fetch(8'h05, 0, 1'b0);
        push(1'b1, 1'b1, 1'b0, 8'h05, 32'h0, 1'b0, 1'b0);
        hand_fetch(8'h06, 0, 1'b0);
        push(1'b1, 1'b1, 1'b0, 8'h06, 32'h20000, 1'b0, 1'b0);
        apply_rows("jumps");

        hand_fetch(8'hFF, 0, 1'b1);
        hand_fetch(8'h01, 1, 1'b0);
        push(1'b1, 1'b0, 1'b0, 8'h01, 32'h40, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0, 8'h01, 32'h20, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b0, 8'h01, 32'h20, 1'b0, 1'b0);
        apply_rows("illegal_store");

        for (int i = 0; i < 4; i++) begin
            hand_fetch(mem_ops[i], 0, 1'b0);
            push(1'b1, 1'b0, 1'b0, mem_ops[i], 32'h4, 1'b0, 1'b0);
            push(1'b1, 1'b0, 1'b0, mem_ops[i], 32'h80, 1'b0, 1'b0);
            push(1'b1, 1'b0, 1'b0, mem_ops[i], bitw(mem_bit[i]), 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            hand_fetch(un_ops[i], 0, 1'b0);
            push(1'b1, 1'b0, 1'b0, un_ops[i], bitw(un_bit[i]), 1'b0, 1'b0);
        end
        apply_rows("alu_ops");

        for (int n = 0; n < 80; n++) begin
            do rop = 8'($urandom_range(0, 16)); while (rop == 8'h07);
            if (rop == 8'h10) rop = 8'($urandom_range(16, 255));
            model_instr(rop, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            apply_rows("random");
        end

        hand_fetch(8'h07, 0, 1'b0);
        for (int i = 0; i < 20; i++) push(rb(), rb(), rb(), 8'h07, 32'h40000, 1'b1, 1'b0);
        apply_rows("halt");
        #2;
        rst = 1'b1;
        #1;
        check_now("halt_rst", 32'h0, 1'b0, 1'b0);

        release_rst(1'b1);
        hand_fetch(8'h02, 1, 1'b0);
        push(1'b0, 1'b0, 1'b0, 8'h02, 32'h4, 1'b0, 1'b0);
        apply_rows("pre_midrst");
        #2;
        rst = 1'b1;
        #1;
        check_now("mid_instr_rst", 32'h0, 1'b0, 1'b0);
        release_rst(1'b0);
        push(1'b1, 1'b0, 1'b0, 8'h03, 32'h0, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b1, 8'h03, 32'h0, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b0, 8'h03, 32'h1, 1'b0, 1'b0);
        apply_rows("restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
